// File: rtl/xrs_param_if.sv
// xrs_param_if: bus bundle between the pipeline and the integer register file.
//
// Groups the write port (we_i/rd_i/rdat_i/wsize_i/wsx_i), the two read ports
// (ra_i/rb_i -> rdata_o/rdatb_o), the pending-load scoreboard port
// (pset_i/prd_i -> pend_a_o/pend_b_o) and the ready_o status flag.
// Signal suffixes are named from the register file's point of view.
//
//   master : decode/writeback side, drives addresses, data and controls
//   slave  : the register file itself
interface xrs_param_if #(
    parameter int XLEN = 64,
    parameter int RW   = 5
);
    logic            ready_o;
    logic            we_i;
    logic [RW-1:0]   rd_i;
    logic [XLEN-1:0] rdat_i;
    logic [1:0]      wsize_i;
    logic            wsx_i;
    logic [RW-1:0]   ra_i;
    logic [RW-1:0]   rb_i;
    logic [XLEN-1:0] rdata_o;
    logic [XLEN-1:0] rdatb_o;
    logic            pset_i;
    logic [RW-1:0]   prd_i;
    logic            pend_a_o;
    logic            pend_b_o;

    modport master (
        output we_i, rd_i, rdat_i, wsize_i, wsx_i, ra_i, rb_i, pset_i, prd_i,
        input  ready_o, rdata_o, rdatb_o, pend_a_o, pend_b_o
    );

    modport slave (
        input  we_i, rd_i, rdat_i, wsize_i, wsx_i, ra_i, rb_i, pset_i, prd_i,
        output ready_o, rdata_o, rdatb_o, pend_a_o, pend_b_o
    );
endinterface

// File: rtl/xrs_param.sv
// xrs_param: parameterised integer register file (XLEN 32/64, NREG 16/32).
//
// Two registered read ports with write-to-read bypass, one write port with a
// size/sign-extension unit, and a per-register pending-load scoreboard.
// After reset an init sequencer zeroes registers 1..NREG-1, one per cycle,
// then raises ready_o. Register 0 is hard-wired to zero and never pending.
//
// Ports:
//   clk_i     rising-edge clock
//   reset_ni  asynchronous active-low reset
//   bus       xrs_param_if slave modport (write, read, scoreboard, ready_o)
module xrs_param #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int RW   = 5
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    xrs_param_if.slave   bus
);
    localparam logic [0:0]      ST_INIT = 1'b0;
    localparam logic [0:0]      ST_RUN  = 1'b1;
    localparam logic [XLEN-1:0] ONES    = '1;
    localparam logic [RW-1:0]   LAST    = RW'(NREG - 1);

    logic [0:0]      state;
    logic [RW-1:0]   clr_cnt;
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;

    logic            run;
    logic            wr_en;
    logic [XLEN-1:0] wmask;
    logic            wsign;
    logic [XLEN-1:0] wval;
    logic [XLEN-1:0] rd_a;
    logic [XLEN-1:0] rd_b;

    assign run   = (state == ST_RUN);
    assign wr_en = run && bus.we_i && (bus.rd_i != '0);

    // Size/extension unit. wsize_i=3 keeps the all-ones mask, so on a 32-bit
    // build it degenerates to the 32-bit case and the sign fill is masked out.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        wmask = ONES;
        wsign = bus.rdat_i[XLEN-1];
        unique case (bus.wsize_i)
            2'd0: begin
                wmask = ONES >> (XLEN - 8);
                wsign = bus.rdat_i[7];
            end
            2'd1: begin
                wmask = ONES >> (XLEN - 16);
                wsign = bus.rdat_i[15];
            end
            2'd2: begin
                wmask = ONES >> (XLEN - 32);
                wsign = bus.rdat_i[31];
            end
            default: begin
                wmask = ONES;
                wsign = bus.rdat_i[XLEN-1];
            end
        endcase
        wval = (bus.rdat_i & wmask) | ((bus.wsx_i && wsign) ? ~wmask : '0);
    end

    // Read muxes: r0 and the whole INIT phase read as zero; a same-cycle
    // write to the addressed register is forwarded instead of the stale entry.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (run && (bus.ra_i != '0))
            rd_a = (wr_en && (bus.rd_i == bus.ra_i)) ? wval : regs[bus.ra_i];
        if (run && (bus.rb_i != '0))
            rd_b = (wr_en && (bus.rd_i == bus.rb_i)) ? wval : regs[bus.rb_i];
    end

    // Scoreboard next state: write clears, then load-issue sets, so a set
    // wins when both hit the same register.
    always_comb begin
        pend_nxt = pend;
        if (wr_en)
            pend_nxt[bus.rd_i] = 1'b0;
        if (run && bus.pset_i)
            pend_nxt[bus.prd_i] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // NOTE: the storage array has no reset; the init sequencer zeroes it,
    // which keeps it mappable to RAM and off the reset network.
    always_ff @(posedge clk_i) begin
        if (!run)
            regs[clr_cnt] <= '0;
        else if (wr_en)
            regs[bus.rd_i] <= wval;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_ni) begin
            state        <= ST_INIT;
            clr_cnt      <= RW'(1);
            bus.ready_o  <= 1'b0;
            bus.rdata_o  <= '0;
            bus.rdatb_o  <= '0;
            bus.pend_a_o <= 1'b0;
            bus.pend_b_o <= 1'b0;
            pend         <= '0;
        end else begin
            if (state == ST_INIT) begin
                if (clr_cnt == LAST) begin
                    state       <= ST_RUN;
                    bus.ready_o <= 1'b1;
                end else begin
                    clr_cnt <= clr_cnt + RW'(1);
                end
            end
            bus.rdata_o  <= rd_a;
            bus.rdatb_o  <= rd_b;
            pend         <= pend_nxt;
            bus.pend_a_o <= pend_nxt[bus.ra_i];
            bus.pend_b_o <= pend_nxt[bus.rb_i];
        end
    end
endmodule

// File: tb/tb_xrs_param.sv
// tb_xrs_param: drives a 64-bit/32-register and a 32-bit/16-register
// instance of xrs_param with identical stimulus and compares both against
// a behavioural model (register arrays, pending bit vectors, arithmetic
// sign extension).
module tb_xrs_param;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    xrs_param_if #(.XLEN(64), .RW(5)) b64 ();
    xrs_param_if #(.XLEN(32), .RW(4)) b32 ();

    xrs_param #(.XLEN(64), .NREG(32), .RW(5)) dut64 (
        .clk_i(clk), .reset_ni(rst_n), .bus(b64)
    );
    xrs_param #(.XLEN(32), .NREG(16), .RW(4)) dut32 (
        .clk_i(clk), .reset_ni(rst_n), .bus(b32)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state.
    logic [63:0] m64 [32];
    logic [31:0] m32 [16];
    logic [31:0] p64;
    logic [15:0] p32;
    logic        run_m = 1'b0;
    logic [4:0]  cur_ra = '0;
    logic [4:0]  cur_rb = '0;

    // Field of width W = min(8<<sz, xlen); sign extension as two's-complement
    // subtraction of 2^W when the top field bit is set.
    function automatic logic [63:0] ext(input logic [63:0] d, input logic [1:0] sz,
                                        input logic sx, input int xlen);
        int w;
        logic [63:0] f;
        w = 8 << sz;
        if (w > xlen) w = xlen;
        f = (w == 64) ? d : (d % (64'd1 << w));
        if (w < xlen && sx && d[w-1]) f = f - (64'd1 << w);
        if (xlen == 32) f = f & 64'h0000_0000_FFFF_FFFF;
        return f;
    endfunction

    function automatic logic [63:0] e64(input logic [4:0] a);
        return (a == 5'd0) ? 64'd0 : m64[a];
    endfunction
    function automatic logic [31:0] e32(input logic [3:0] a);
        return (a == 4'd0) ? 32'd0 : m32[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m64[i] = '0;
        for (int i = 0; i < 16; i++) m32[i] = '0;
        p64 = '0;
        p32 = '0;
    endtask

    // One clock of stimulus to both instances; model applies write, then
    // scoreboard clear, then set, so reads see post-update contents.
    task automatic drive(input logic we, input logic [4:0] rd, input logic [63:0] dat,
                         input logic [1:0] sz, input logic sx,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input logic ps, input logic [4:0] prd);
        logic [63:0] v;
        b64.we_i = we;  b64.rd_i = rd;  b64.rdat_i = dat;
        b64.wsize_i = sz; b64.wsx_i = sx; b64.ra_i = ra; b64.rb_i = rb;
        b64.pset_i = ps; b64.prd_i = prd;
        b32.we_i = we;  b32.rd_i = rd[3:0]; b32.rdat_i = dat[31:0];
        b32.wsize_i = sz; b32.wsx_i = sx; b32.ra_i = ra[3:0]; b32.rb_i = rb[3:0];
        b32.pset_i = ps; b32.prd_i = prd[3:0];
        @(posedge clk);
        if (run_m) begin
            if (we && rd != 5'd0) begin
                m64[rd] = ext(dat, sz, sx, 64);
                p64[rd] = 1'b0;
            end
            if (ps && prd != 5'd0) p64[prd] = 1'b1;
            if (we && rd[3:0] != 4'd0) begin
                v = ext(dat, sz, sx, 32);
                m32[rd[3:0]] = v[31:0];
                p32[rd[3:0]] = 1'b0;
            end
            if (ps && prd[3:0] != 4'd0) p32[prd[3:0]] = 1'b1;
        end
        cur_ra = ra;
        cur_rb = rb;
        #1;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 5'd3, 5'd31, 1'b0, 5'd0);
    endtask

    task automatic test_reset();
        run_m = 1'b0;
        model_clear();
        b64.ra_i = 5'd3; b64.rb_i = 5'd31; b32.ra_i = 4'd3; b32.rb_i = 4'd15;
        b64.we_i = 1'b0; b64.pset_i = 1'b0; b32.we_i = 1'b0; b32.pset_i = 1'b0;
        b64.rd_i = '0; b64.prd_i = '0; b64.rdat_i = '0; b64.wsize_i = '0; b64.wsx_i = 1'b0;
        b32.rd_i = '0; b32.prd_i = '0; b32.rdat_i = '0; b32.wsize_i = '0; b32.wsx_i = 1'b0;
        rst_n = 1'b0;
        #3;
        n_tests++;
        if (b64.ready_o !== 1'b0 || b32.ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b/%b expected 0/0", b64.ready_o, b32.ready_o);
        end
        n_tests++;
        if (b64.rdata_o !== 64'd0 || b64.rdatb_o !== 64'd0 || b64.pend_a_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out64: got %h %h %b expected zeros",
                     b64.rdata_o, b64.rdatb_o, b64.pend_a_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            n_tests++;
            if (b64.ready_o !== (k >= 31)) begin
                n_fail++;
                $display("FAIL init64_ready edge %0d: got %b expected %b", k, b64.ready_o, k >= 31);
            end
            n_tests++;
            if (b32.ready_o !== (k >= 15)) begin
                n_fail++;
                $display("FAIL init32_ready edge %0d: got %b expected %b", k, b32.ready_o, k >= 15);
            end
            if (k < 31) begin
                n_tests++;
                if (b64.rdata_o !== 64'd0 || b64.rdatb_o !== 64'd0) begin
                    n_fail++;
                    $display("FAIL init64_read edge %0d: got %h %h expected 0", k,
                             b64.rdata_o, b64.rdatb_o);
                end
            end
        end
    endtask

    task automatic test_reset_mid_init();
        run_m = 1'b0;
        model_clear();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #2;
        n_tests++;
        if (b64.ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midinit_reset_ready: got %b expected 0", b64.ready_o);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk); #1;
            n_tests++;
            if (b64.ready_o !== (k >= 31)) begin
                n_fail++;
                $display("FAIL midinit64_ready edge %0d: got %b expected %b", k, b64.ready_o, k >= 31);
            end
        end
        run_m = 1'b1;
        for (int i = 0; i < 32; i += 2) begin
            drive(1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 5'(i), 5'(i + 1), 1'b0, 5'd0);
            n_tests++;
            if (b64.rdata_o !== 64'd0 || b64.rdatb_o !== 64'd0 ||
                b32.rdata_o !== 32'd0 || b32.rdatb_o !== 32'd0) begin
                n_fail++;
                $display("FAIL zeroed r%0d/r%0d: got %h %h %h %h expected 0", i, i + 1,
                         b64.rdata_o, b64.rdatb_o, b32.rdata_o, b32.rdatb_o);
            end
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 5'd1, 64'h1122334455667788, 2'd3, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        drive(1'b1, 5'd2, 64'h7766554433221100, 2'd3, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
        drive(1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0);
        n_tests++;
        if (b64.rdata_o !== 64'h1122334455667788 || b64.rdatb_o !== 64'h7766554433221100) begin
            n_fail++;
            $display("FAIL basic_read: got %h %h expected 1122334455667788 7766554433221100",
                     b64.rdata_o, b64.rdatb_o);
        end
        n_tests++;
        if (b32.rdata_o !== 32'h55667788 || b32.rdatb_o !== 32'h33221100) begin
            n_fail++;
            $display("FAIL basic_read32: got %h %h expected 55667788 33221100",
                     b32.rdata_o, b32.rdatb_o);
        end
        drive(1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 5'd2, 5'd1, 1'b0, 5'd0);
        n_tests++;
        if (b64.rdata_o !== 64'h7766554433221100 || b64.rdatb_o !== 64'h1122334455667788) begin
            n_fail++;
            $display("FAIL basic_swap: got %h %h expected 7766554433221100 1122334455667788",
                     b64.rdata_o, b64.rdatb_o);
        end
        drive(1'b1, 5'd0, 64'hFFFFFFFFFFFFFFFF, 2'd3, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0);
        drive(1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        n_tests++;
        if (b64.rdata_o !== 64'd0 || b64.rdatb_o !== 64'd0 || b32.rdata_o !== 32'd0 ||
            b64.pend_a_o !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_zero: got %h %h %h pend %b expected 0", b64.rdata_o,
                     b64.rdatb_o, b32.rdata_o, b64.pend_a_o);
        end
    endtask

    task automatic test_ext();
        drive(1'b1, 5'd3, 64'h00000000000080F0, 2'd0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
        drive(1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 5'd3, 5'd0, 1'b0, 5'd0);
        n_tests++;
        if (b64.rdata_o !== 64'hFFFFFFFFFFFFFFF0 || b32.rdata_o !== 32'hFFFFFFF0) begin
            n_fail++;
            $display("FAIL ext_b_sx: got %h %h expected FFFFFFFFFFFFFFF0 FFFFFFF0",
                     b64.rdata_o, b32.rdata_o);
        end
        drive(1'b1, 5'd3, 64'h00000000000080F0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        drive(1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 5'd3, 5'd0, 1'b0, 5'd0);
        n_tests++;
        if (b64.rdata_o !== 64'h00000000000000F0 || b32.rdata_o !== 32'h000000F0) begin
            n_fail++;
            $display("FAIL ext_b_zx: got %h %h expected 00000000000000F0 000000F0",
                     b64.rdata_o, b32.rdata_o);
        end
        drive(1'b1, 5'd3, 64'h00000000000080F0, 2'd1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
        drive(1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 5'd3, 5'd0, 1'b0, 5'd0);
        n_tests++;
        if (b64.rdata_o !== 64'hFFFFFFFFFFFF80F0 || b32.rdata_o !== 32'hFFFF80F0) begin
            n_fail++;
            $display("FAIL ext_h_sx: got %h %h expected FFFFFFFFFFFF80F0 FFFF80F0",
                     b64.rdata_o, b32.rdata_o);
        end
        drive(1'b1, 5'd6, 64'h0000000080000001, 2'd2, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
        drive(1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 5'd6, 5'd0, 1'b0, 5'd0);
        n_tests++;
        if (b64.rdata_o !== 64'hFFFFFFFF80000001) begin
            n_fail++;
            $display("FAIL ext_w_sx: got %h expected FFFFFFFF80000001", b64.rdata_o);
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd5, 64'h00000000DEADBEEF, 2'd3, 1'b0, 5'd5, 5'd5, 1'b0, 5'd0);
        n_tests++;
        if (b64.rdata_o !== 64'h00000000DEADBEEF || b64.rdatb_o !== 64'h00000000DEADBEEF) begin
            n_fail++;
            $display("FAIL bypass64: got %h %h expected 00000000DEADBEEF", b64.rdata_o, b64.rdatb_o);
        end
        n_tests++;
        if (b32.rdata_o !== 32'hDEADBEEF || b32.rdatb_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL bypass32: got %h %h expected DEADBEEF", b32.rdata_o, b32.rdatb_o);
        end
    endtask

    task automatic test_scoreboard();
        drive(1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 5'd7, 5'd8, 1'b1, 5'd7);
        n_tests++;
        if (b64.pend_a_o !== 1'b1 || b64.pend_b_o !== 1'b0 || b32.pend_a_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_set: got %b %b %b expected 1 0 1", b64.pend_a_o,
                     b64.pend_b_o, b32.pend_a_o);
        end
        drive(1'b1, 5'd7, 64'h1234, 2'd3, 1'b0, 5'd7, 5'd7, 1'b1, 5'd7);
        n_tests++;
        if (b64.pend_a_o !== 1'b1 || b64.pend_b_o !== 1'b1 || b32.pend_a_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_set_wins: got %b %b %b expected 1 1 1", b64.pend_a_o,
                     b64.pend_b_o, b32.pend_a_o);
        end
        drive(1'b1, 5'd7, 64'h5678, 2'd3, 1'b0, 5'd7, 5'd0, 1'b0, 5'd0);
        n_tests++;
        if (b64.pend_a_o !== 1'b0 || b32.pend_a_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_clear: got %b %b expected 0 0", b64.pend_a_o, b32.pend_a_o);
        end
    endtask

    task automatic test_xlen32();
        drive(1'b1, 5'd4, 64'h0000000080000001, 2'd3, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
        drive(1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 5'd4, 5'd0, 1'b0, 5'd0);
        n_tests++;
        if (b32.rdata_o !== 32'h80000001) begin
            n_fail++;
            $display("FAIL xlen32_dword: got %h expected 80000001", b32.rdata_o);
        end
    endtask

    task automatic test_random();
        logic [4:0] rd, ra, rb, prd;
        for (int i = 0; i < 400; i++) begin
            rd  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            ra  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            rb  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            prd = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            drive(1'($urandom), rd, {$urandom, $urandom}, 2'($urandom), 1'($urandom),
                  ra, rb, ($urandom_range(0, 3) == 0), prd);
            n_tests++;
            if (b64.rdata_o !== e64(cur_ra) || b64.rdatb_o !== e64(cur_rb)) begin
                n_fail++;
                $display("FAIL rand64_read #%0d ra=%0d rb=%0d: got %h %h expected %h %h", i,
                         cur_ra, cur_rb, b64.rdata_o, b64.rdatb_o, e64(cur_ra), e64(cur_rb));
            end
            n_tests++;
            if (b32.rdata_o !== e32(cur_ra[3:0]) || b32.rdatb_o !== e32(cur_rb[3:0])) begin
                n_fail++;
                $display("FAIL rand32_read #%0d: got %h %h expected %h %h", i,
                         b32.rdata_o, b32.rdatb_o, e32(cur_ra[3:0]), e32(cur_rb[3:0]));
            end
            n_tests++;
            if (b64.pend_a_o !== p64[cur_ra] || b64.pend_b_o !== p64[cur_rb] ||
                b32.pend_a_o !== p32[cur_ra[3:0]] || b32.pend_b_o !== p32[cur_rb[3:0]]) begin
                n_fail++;
                $display("FAIL rand_pend #%0d: got %b%b %b%b expected %b%b %b%b", i,
                         b64.pend_a_o, b64.pend_b_o, b32.pend_a_o, b32.pend_b_o,
                         p64[cur_ra], p64[cur_rb], p32[cur_ra[3:0]], p32[cur_rb[3:0]]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_init();
        test_basic();
        test_ext();
        test_bypass();
        test_scoreboard();
        test_xlen32();
        test_random();
        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
